// File: rtl/sys_defs.sv
// sys_defs: shared fetch-path types, opcode constants and sizing
package sys_defs;
  localparam int FB_DEPTH = 4;
  localparam int OBQ_SIZE = 8;
  localparam int OBQ_IDX_W = $clog2(OBQ_SIZE) + 1;
  localparam logic [5:0] OP_JMP_IND = 6'h1A;
  localparam logic [5:0] OP_BR = 6'h30;
  localparam logic [5:0] OP_BSR = 6'h34;
  localparam logic [5:0] OP_CBR_LO = 6'h31;
  localparam logic [5:0] OP_CBR_HI = 6'h3F;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_BP, S_DROP} fetch_state_e;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic pred_taken;
    logic [OBQ_IDX_W-1:0] obq_index;
  } FB_ENTRY_T;
  // returns {is_branch, conditional, direct}
  function automatic logic [2:0] predecode(input logic [5:0] op);
    logic cond, direct;
    cond = op >= OP_CBR_LO && op <= OP_CBR_HI && op != OP_BSR;
    direct = cond || op == OP_BR || op == OP_BSR;
    return {direct || op == OP_JMP_IND, cond, direct};
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus
interface fetch_unit_if;
  logic proc2Imem_req;
  logic [31:0] proc2Imem_addr;
  logic Imem2proc_valid;
  logic [31:0] Imem2proc_data;
  modport master(output proc2Imem_req, proc2Imem_addr, input Imem2proc_valid, Imem2proc_data);
  modport slave(input proc2Imem_req, proc2Imem_addr, output Imem2proc_valid, Imem2proc_data);
endinterface

// File: rtl/fetch_unit_buffer.sv
// fetch_buffer: circular FIFO of predecoded fetch entries with flush
module fetch_buffer #(
  parameter int DEPTH = sys_defs::FB_DEPTH
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  sys_defs::FB_ENTRY_T push_entry,
  output logic full,
  output logic empty,
  output sys_defs::FB_ENTRY_T head_entry
);
  import sys_defs::*;
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] head_q, tail_q;
  logic [AW:0] count_q;
  FB_ENTRY_T mem_q [DEPTH];
  assign full = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign head_entry = mem_q[head_q];
  // flush drops everything by snapping head to tail; otherwise push/pop move the pointers
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      head_q <= tail_q;
      count_q <= '0;
    end else begin
      if (push) mem_q[tail_q] <= push_entry;
      if (push) tail_q <= tail_q + 1'b1;
      if (pop) head_q <= head_q + 1'b1;
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: one-outstanding-request fetch FSM with predecode and predictor handshake
module fetch_unit #(
  parameter int FB_DEPTH = sys_defs::FB_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic clock,
  input  logic reset,
  fetch_unit_if.master imem,
  output logic [31:0] if_pc_in,
  output logic if_en_branch,
  output logic if_cond_branch,
  output logic if_direct_branch,
  input  logic bp_next_pc_valid,
  input  logic [31:0] bp_next_pc,
  input  logic [sys_defs::OBQ_IDX_W-1:0] bp_next_pc_index,
  input  logic bp_next_pc_prediction,
  input  logic rt_mispredict,
  input  logic [31:0] rt_target_pc,
  input  logic id_ready,
  output logic fb_valid,
  output logic [31:0] fb_inst,
  output logic [31:0] fb_pc,
  output logic [31:0] fb_npc,
  output logic fb_pred_taken,
  output logic [sys_defs::OBQ_IDX_W-1:0] fb_obq_index
);
  import sys_defs::*;
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, npc;
  logic [2:0] pd;
  logic push, pop, full, empty;
  FB_ENTRY_T push_entry, head;
  assign pd = predecode(imem.Imem2proc_data[31:26]);
  assign npc = bp_next_pc_valid ? bp_next_pc : pc_q + 32'd4;
  assign pop = !empty && id_ready && !rt_mispredict;
  assign imem.proc2Imem_addr = {pc_q[31:2], 2'b00};
  assign if_pc_in = pc_q;
  assign fb_valid = !empty;
  assign fb_inst = head.inst;
  assign fb_pc = head.pc;
  assign fb_npc = head.npc;
  assign fb_pred_taken = head.pred_taken;
  assign fb_obq_index = head.obq_index;
  fetch_buffer #(.DEPTH(FB_DEPTH)) u_fb (
    .clock(clock), .reset(reset), .push(push), .pop(pop), .flush(rt_mispredict),
    .push_entry(push_entry), .full(full), .empty(empty), .head_entry(head)
  );
  // next state, request strobe, predecode and push; a redirect overrides everything and
  // parks in S_DROP whenever a response is still owed by the memory
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    inst_d = inst_q;
    push = 1'b0;
    push_entry = '{inst: imem.Imem2proc_data, pc: pc_q, npc: pc_q + 32'd4, pred_taken: 1'b0, obq_index: '0};
    imem.proc2Imem_req = 1'b0;
    {if_en_branch, if_cond_branch, if_direct_branch} = 3'b000;
    if (rt_mispredict) begin
      pc_d = rt_target_pc;
      state_d = (state_q == S_WAIT || state_q == S_DROP) && !imem.Imem2proc_valid ? S_DROP : S_REQ;
    end else begin
      unique case (state_q)
        S_REQ: if (!full) begin
          imem.proc2Imem_req = reset;
          state_d = S_WAIT;
        end
        S_WAIT: if (imem.Imem2proc_valid) begin
          {if_en_branch, if_cond_branch, if_direct_branch} = pd;
          inst_d = imem.Imem2proc_data;
          push = !pd[2];
          pc_d = pd[2] ? pc_q : pc_q + 32'd4;
          state_d = pd[2] ? S_BP : S_REQ;
        end
        S_BP: begin
          push = 1'b1;
          push_entry = '{inst: inst_q, pc: pc_q, npc: npc, pred_taken: bp_next_pc_prediction, obq_index: bp_next_pc_index};
          pc_d = npc;
          state_d = S_REQ;
        end
        S_DROP: state_d = imem.Imem2proc_valid ? S_REQ : S_DROP;
      endcase
    end
  end
  // FSM, PC and latched branch instruction
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= S_REQ;
      pc_q <= RESET_PC;
      inst_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      inst_q <= inst_d;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter FB_DEPTH, default 4: fetch-buffer entries, power of two, at least 2.
REQ-002 SHALL have parameter RESET_PC, default 32'h0: first fetch address.
REQ-003 SHALL have port `clock`: input, 1 bit; sole clock, rising edge.
REQ-004 SHALL have port `reset`: input, 1 bit; asynchronous, active-low.
REQ-005 SHALL have port `proc2Imem_req`: output, 1 bit; instruction-memory request strobe.
REQ-006 SHALL have port `proc2Imem_addr`: output, 32 bits; request address, word-aligned.
REQ-007 SHALL have port `Imem2proc_valid`: input, 1 bit; response valid.
REQ-008 SHALL have port `Imem2proc_data`: input, 32 bits; instruction word.
REQ-009 SHALL have port `if_pc_in`: output, 32 bits; PC of the instruction being predecoded, to the branch predictor.
REQ-010 SHALL have ports `if_en_branch`, `if_cond_branch`, `if_direct_branch`: outputs, 1 bit each; predecode class.
REQ-011 SHALL have ports `bp_next_pc_valid` (input, 1 bit) and `bp_next_pc` (input, 32 bits): predictor result.
REQ-012 SHALL have ports `bp_next_pc_index` (input, $clog2(OBQ_SIZE)+1 bits) and `bp_next_pc_prediction` (input, 1 bit): predictor result.
REQ-013 SHALL have ports `rt_mispredict` (input, 1 bit) and `rt_target_pc` (input, 32 bits): retire redirect.
REQ-014 SHALL have port `id_ready`: input, 1 bit; decode accepts the head entry.
REQ-015 SHALL have port `fb_valid`: output, 1 bit; head entry valid.
REQ-016 SHALL have ports `fb_inst` and `fb_pc`: outputs, 32 bits each; head instruction and its PC.
REQ-017 SHALL have ports `fb_npc` (output, 32 bits) and `fb_pred_taken` (output, 1 bit): head predicted next PC and direction.
REQ-018 SHALL have port `fb_obq_index`: output, $clog2(OBQ_SIZE)+1 bits; head OBQ index.

Function
REQ-019 SHALL implement FSM states S_REQ, S_WAIT, S_BP, S_DROP.
REQ-020 S_REQ: when buffer count < FB_DEPTH, SHALL assert proc2Imem_req with proc2Imem_addr=pc for one cycle and go to S_WAIT; otherwise hold with no request.
REQ-021 S_WAIT SHALL hold until Imem2proc_valid; at most one request outstanding.
REQ-022 On response, SHALL predecode opcode [31:26]: 0x31-0x33 and 0x35-0x3F conditional direct; 0x30 and 0x34 unconditional direct; 0x1A unconditional indirect; others non-branch.
REQ-023 SHALL assert if_en_branch and the class bits combinationally in the response cycle, with if_pc_in=pc; all three SHALL be 0 in every other cycle.
REQ-024 On a non-branch response, SHALL push {inst, pc, npc=pc+4, taken=0, index=0}, set pc<=pc+4 and go to S_REQ in the same cycle.
REQ-025 On a branch response, SHALL latch inst and go to S_BP.
REQ-026 In S_BP (next cycle), SHALL set npc=bp_next_pc if bp_next_pc_valid, else pc+4; SHALL push {inst, pc, npc, bp_next_pc_prediction, bp_next_pc_index}, set pc<=npc and go to S_REQ.
REQ-027 PC arithmetic SHALL be 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0.
REQ-028 Buffer SHALL be circular with head/tail/count; count range 0..FB_DEPTH.
REQ-029 fb_valid SHALL equal (count != 0); fb_* SHALL show the head entry.
REQ-030 Pop SHALL occur on fb_valid & id_ready; simultaneous push and pop SHALL leave count unchanged.
REQ-031 No push SHALL occur when full; the issue gate in REQ-020 guarantees this.
REQ-032 rt_mispredict SHALL have priority over every other event in the same cycle.
REQ-033 rt_mispredict SHALL empty the buffer (count<=0, head<=tail), suppress that cycle's push and pop, and set pc<=rt_target_pc.
REQ-034 rt_mispredict SHALL move S_WAIT (response not in same cycle) to S_DROP, and all other states (or S_WAIT with same-cycle response) to S_REQ.
REQ-035 S_DROP SHALL discard the next response and go to S_REQ, with no predecode or push.
REQ-036 rt_mispredict while in S_DROP SHALL update pc and stay in S_DROP.

Reset
REQ-037 On reset low, SHALL immediately set state=S_REQ, pc=RESET_PC, head=tail=count=0 and all fb_* outputs 0.
REQ-038 proc2Imem_req SHALL be 0 while reset is low.
REQ-039 Reset mid-transaction SHALL abandon any outstanding response; the memory is reset together with this block.
REQ-040 The first request SHALL be issued in the first cycle after reset deasserts.

Structure
REQ-041 Opcode constants, FB_DEPTH and FB_ENTRY_T {inst, pc, npc, pred_taken, obq_index} SHALL reside in the shared sys_defs package; OBQ_SIZE SHALL be reused from it.
REQ-042 The FIFO SHALL be sub-module fetch_buffer (push, pop, flush, full, empty, head entry); FSM and predecode SHALL stay in fetch_unit.

Verification
REQ-043 SHALL cover non-branch stream: reset, then memory returns 0x00000000 each cycle after request -> PCs 0,4,8,C pushed with npc=pc+4.
REQ-044 SHALL cover taken conditional: opcode 0x39 at pc 0x10, bp_next_pc_valid=1, bp_next_pc=0x80, prediction=1, index=3 -> if_cond_branch=1 in the response cycle; entry {0x10, npc 0x80, taken 1, idx 3}; next request 0x80.
REQ-045 SHALL cover full buffer: id_ready=0 -> exactly 4 entries, then no requests; one pop -> one new request.
REQ-046 SHALL cover redirect: rt_mispredict with target 0x200 while in S_WAIT -> buffer empty, stale response dropped, next request 0x200.
REQ-047 SHALL cover simultaneous events: push and pop same cycle keep count; rt_mispredict in S_BP -> no push, next request at rt_target_pc.
